// File: rtl/sprite_pos_regs_if.sv
// CPU store/load bus for the sprite position register file.
// The master drives the store strobe, address and data. The slave returns
// read-back data, which is only meaningful when SPRITE_POS_READBACK_EN is defined.
interface sprite_pos_regs_if;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/sprite_pos_regs.sv
// Sprite position register file with a once-per-frame commit.
// CPU stores land in six shadow registers. On the clock edge that recognises the
// start of vertical sync, each shadow is copied to its live output. X values are
// clamped to H_RES-1 and Y values to V_RES-1 on the way out.
// The module also provides a frame counter and a one-cycle frame tick.
// Optional feature macro: SPRITE_POS_READBACK_EN. When it is defined, mem_rdata
// returns the shadow value one cycle after the address is presented.
module sprite_pos_regs #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int MX    = 6000,
  parameter int MY    = 6004,
  parameter int P1X   = 6008,
  parameter int P1Y   = 6012,
  parameter int P2X   = 6016,
  parameter int P2Y   = 6020
) (
  input  logic              clk_50MHz,
  input  logic              clear,
  sprite_pos_regs_if.slave  bus,
  input  logic              v_sync,
  output logic [15:0]       mx,
  output logic [15:0]       my,
  output logic [15:0]       p1x,
  output logic [15:0]       p1y,
  output logic [15:0]       p2x,
  output logic [15:0]       p2y,
  output logic              frame_tick,
  output logic [15:0]       frame_cnt,
  output logic              pending
);

  localparam int          NREG  = 6;
  localparam logic [15:0] X_MAX = 16'(H_RES - 1);
  localparam logic [15:0] Y_MAX = 16'(V_RES - 1);
  // Register order: even entries are X coordinates and odd entries are Y coordinates.
  localparam logic [15:0] ADDR_TAB [NREG] = '{16'(MX), 16'(MY), 16'(P1X),
                                              16'(P1Y), 16'(P2X), 16'(P2Y)};

  logic [15:0]     shadow_q [NREG];
  logic [15:0]     shadow_d [NREG];
  logic [15:0]     live_q   [NREG];
  logic [15:0]     live_d   [NREG];
  logic [NREG-1:0] hit;

  logic            s1_q, s2_q, s3_q;
  // Marks which synchroniser stages hold a real post-reset sample rather than
  // the idle-high reset value. Without it, v_sync already low at reset release
  // would look like a falling edge.
  logic [2:0]      vld_q;
  logic            commit;

  logic            frame_tick_q;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            pending_q, pending_d;

  assign commit = s3_q & ~s2_q & vld_q[2];

  // Per-register address decode, shadow update and clamped commit value.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [15:0] LIM = (gi % 2 == 0) ? X_MAX : Y_MAX;
      assign hit[gi]      = bus.mem_we && (bus.mem_addr == ADDR_TAB[gi]);
      assign shadow_d[gi] = hit[gi] ? bus.mem_wdata : shadow_q[gi];
      assign live_d[gi]   = commit ? ((shadow_q[gi] > LIM) ? LIM : shadow_q[gi])
                                   : live_q[gi];
    end
  endgenerate

  // A store on the commit edge still counts as pending for the next frame.
  assign pending_d   = commit ? (|hit) : (pending_q | (|hit));
  assign frame_cnt_d = commit ? frame_cnt_q + 16'd1 : frame_cnt_q;

  // v_sync synchroniser and validity chain; the synchroniser idles high.
  always_ff @(posedge clk_50MHz or negedge clear) begin
    if (!clear) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      s3_q  <= 1'b1;
      vld_q <= 3'b000;
    end else begin
      s1_q  <= v_sync;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      vld_q <= {vld_q[1:0], 1'b1};
    end
  end

  // Shadow registers, live outputs and frame bookkeeping.
  always_ff @(posedge clk_50MHz or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
      pending_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= shadow_d[i];
        live_q[i]   <= live_d[i];
      end
      frame_tick_q <= commit;
      frame_cnt_q  <= frame_cnt_d;
      pending_q    <= pending_d;
    end
  end

  assign mx         = live_q[0];
  assign my         = live_q[1];
  assign p1x        = live_q[2];
  assign p1y        = live_q[3];
  assign p2x        = live_q[4];
  assign p2y        = live_q[5];
  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;
  assign pending    = pending_q;

`ifdef SPRITE_POS_READBACK_EN
  logic [15:0] rdata_q, rdata_d;

  // Read mux over the shadows. A store in the same cycle is not yet visible.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.mem_addr == ADDR_TAB[i]) rdata_d = shadow_q[i];
    end
  end

  // Registered read data, one cycle of latency.
  always_ff @(posedge clk_50MHz or negedge clear) begin
    if (!clear) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign bus.mem_rdata = rdata_q;
`else
  assign bus.mem_rdata = '0;
`endif

endmodule

// File: tb/tb_sprite_pos_regs.sv
// Self-checking bench for sprite_pos_regs.
// It applies a table of hand-derived vectors, directed corner-case sequences
// and randomized traffic. Every cycle is compared with a behavioural model
// built on a queue of v_sync sample history.
module tb_sprite_pos_regs;

  logic        clk = 1'b0;
  logic        clear;
  logic        v_sync;
  logic [15:0] mx, my, p1x, p1y, p2x, p2y;
  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic        pending;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  sprite_pos_regs_if bus ();

  sprite_pos_regs dut (
    .clk_50MHz (clk),
    .clear     (clear),
    .bus       (bus),
    .v_sync    (v_sync),
    .mx        (mx),
    .my        (my),
    .p1x       (p1x),
    .p1y       (p1y),
    .p2x       (p2x),
    .p2y       (p2y),
    .frame_tick(frame_tick),
    .frame_cnt (frame_cnt),
    .pending   (pending)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_shadow [6];
  logic [15:0] m_live   [6];
  logic [15:0] m_cnt;
  logic [15:0] m_rdata;
  bit          m_tick, m_pend;
  int          hist[$];   // v_sync samples per edge; 2 means "no valid sample since reset"
  string       names [6] = '{"mx", "my", "p1x", "p1y", "p2x", "p2y"};

  function automatic int addr_idx(logic [15:0] a);
    for (int i = 0; i < 6; i++) if (a == 16'(6000 + 4 * i)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_shadow[i] = '0;
      m_live[i]   = '0;
    end
    m_cnt   = '0;
    m_rdata = '0;
    m_tick  = 1'b0;
    m_pend  = 1'b0;
    hist.delete();
    repeat (3) hist.push_back(2);
  endtask

  // A commit occurs when the level three edges back was high and the level
  // two edges back was low.
  task automatic model_edge(bit we, logic [15:0] addr, logic [15:0] data, bit vs);
    int  n   = hist.size();
    int  idx = addr_idx(addr);
    bit  c   = (hist[n-3] == 1) && (hist[n-2] == 0);
`ifdef SPRITE_POS_READBACK_EN
    m_rdata = (idx >= 0) ? m_shadow[idx] : 16'd0;
`else
    m_rdata = 16'd0;
`endif
    m_tick = c;
    if (c) begin
      for (int i = 0; i < 6; i++) begin
        int lim = (i % 2 == 0) ? 639 : 479;
        m_live[i] = (int'(m_shadow[i]) > lim) ? 16'(lim) : m_shadow[i];
      end
      m_cnt  = m_cnt + 16'd1;
      m_pend = 1'b0;
    end
    if (we && idx >= 0) begin
      m_shadow[idx] = data;
      m_pend        = 1'b1;
    end
    hist.push_back(vs ? 1 : 0);
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [15:0] act [6];
    act = '{mx, my, p1x, p1y, p2x, p2y};
    for (int i = 0; i < 6; i++) chk(names[i], 32'(act[i]), 32'(m_live[i]));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("mem_rdata", 32'(bus.mem_rdata), 32'(m_rdata));
  endtask

  // Drive one cycle of inputs, step the model at the edge, then compare 1 ns later.
  task automatic apply(bit we, logic [15:0] addr, logic [15:0] data, bit vs);
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    v_sync        = vs;
    @(posedge clk);
    model_edge(we, addr, data, vs);
    #1;
    compare_all();
  endtask

  task automatic idle(bit vs, int n);
    for (int i = 0; i < n; i++) apply(1'b0, 16'd0, 16'd0, vs);
  endtask

  // High for 3 cycles, then low for 3. The commit lands on the last low cycle.
  task automatic do_frame();
    idle(1'b1, 3);
    idle(1'b0, 3);
  endtask

  task automatic do_reset(bit vs_level);
    clear = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      v_sync = vs_level ? 1'b1 : i[0];
      @(posedge clk);
      #1;
      compare_all();
    end
    clear = 1'b1;
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
    bit          vs;
    logic [15:0] e_mx;
    logic [15:0] e_my;
    bit          e_tick;
    bit          e_pend;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tab [9];

  initial begin
    int ticks;

    // Post-reset frame: two stores mid-frame, then a v_sync falling edge.
    // The first low sample is row 4, so the commit shows on row 6.
    tab[0] = '{1'b0, 16'd0,    16'd0,   1'b1, 16'd0,   16'd0,  1'b0, 1'b0, 16'd0};
    tab[1] = '{1'b1, 16'd6000, 16'd100, 1'b1, 16'd0,   16'd0,  1'b0, 1'b1, 16'd0};
    tab[2] = '{1'b1, 16'd6004, 16'd50,  1'b1, 16'd0,   16'd0,  1'b0, 1'b1, 16'd0};
    tab[3] = '{1'b0, 16'd0,    16'd0,   1'b1, 16'd0,   16'd0,  1'b0, 1'b1, 16'd0};
    tab[4] = '{1'b0, 16'd0,    16'd0,   1'b0, 16'd0,   16'd0,  1'b0, 1'b1, 16'd0};
    tab[5] = '{1'b0, 16'd0,    16'd0,   1'b0, 16'd0,   16'd0,  1'b0, 1'b1, 16'd0};
    tab[6] = '{1'b0, 16'd0,    16'd0,   1'b0, 16'd100, 16'd50, 1'b1, 1'b0, 16'd1};
    tab[7] = '{1'b0, 16'd0,    16'd0,   1'b0, 16'd100, 16'd50, 1'b0, 1'b0, 16'd1};
    tab[8] = '{1'b0, 16'd0,    16'd0,   1'b1, 16'd100, 16'd50, 1'b0, 1'b0, 16'd1};

    clear         = 1'b1;
    v_sync        = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    @(posedge clk);
    #1;

    // Reset with v_sync toggling: all outputs stay zero.
    do_reset(1'b0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);

    // Table-driven first frame.
    for (int r = 0; r < 9; r++) begin
      apply(tab[r].we, tab[r].addr, tab[r].data, tab[r].vs);
      chk($sformatf("tab%0d_mx", r), 32'(mx), 32'(tab[r].e_mx));
      chk($sformatf("tab%0d_my", r), 32'(my), 32'(tab[r].e_my));
      chk($sformatf("tab%0d_tick", r), 32'(frame_tick), 32'(tab[r].e_tick));
      chk($sformatf("tab%0d_pend", r), 32'(pending), 32'(tab[r].e_pend));
      chk($sformatf("tab%0d_cnt", r), 32'(frame_cnt), 32'(tab[r].e_cnt));
    end

    // Clamp: the outputs saturate, while the shadow keeps the raw value.
    apply(1'b1, 16'd6008, 16'd700, 1'b1);
    apply(1'b1, 16'd6012, 16'hFFFF, 1'b1);
    do_frame();
    chk("clamp_p1x", 32'(p1x), 32'd639);
    chk("clamp_p1y", 32'(p1y), 32'd479);
    apply(1'b0, 16'd6008, 16'd0, 1'b0);
`ifdef SPRITE_POS_READBACK_EN
    chk("readback_p1x", 32'(bus.mem_rdata), 32'd700);
`else
    chk("readback_tied", 32'(bus.mem_rdata), 32'd0);
`endif

    // Collision: a store on the commit edge waits for the next frame.
    apply(1'b1, 16'd6016, 16'd5, 1'b1);
    do_frame();
    chk("coll_pre_p2x", 32'(p2x), 32'd5);
    idle(1'b1, 3);
    idle(1'b0, 2);
    apply(1'b1, 16'd6016, 16'd20, 1'b0);
    chk("coll_tick", 32'(frame_tick), 32'd1);
    chk("coll_old_p2x", 32'(p2x), 32'd5);
    chk("coll_pend", 32'(pending), 32'd1);
    do_frame();
    chk("coll_new_p2x", 32'(p2x), 32'd20);
    chk("coll_pend_clr", 32'(pending), 32'd0);

    // Decode: near-miss addresses are ignored.
    apply(1'b1, 16'd6001, 16'd77, 1'b0);
    apply(1'b1, 16'd6024, 16'd77, 1'b0);
    apply(1'b1, 16'd5996, 16'd77, 1'b0);
    chk("decode_pend", 32'(pending), 32'd0);
    // A long low v_sync produces exactly one tick.
    idle(1'b1, 3);
    ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      apply(1'b0, 16'd0, 16'd0, 1'b0);
      ticks += int'(frame_tick);
    end
    chk("long_low_ticks", 32'(ticks), 32'd1);

    // Wrap: preload the counter just below overflow.
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    do_frame();
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);

    // Reset asserted while v_sync is low: a fresh high-to-low edge is required.
    do_reset(1'b1);
    v_sync = 1'b0;
    ticks  = 0;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 16'd0, 16'd0, 1'b0);
      ticks += int'(frame_tick);
    end
    chk("rst_low_no_commit", 32'(ticks), 32'd0);
    do_frame();
    chk("rst_fresh_commit", 32'(frame_tick), 32'd1);
    chk("rst_fresh_cnt", 32'(frame_cnt), 32'd1);

    // Randomized traffic against the model.
    begin
      bit vs  = 1'b1;
      int run = 0;
      for (int i = 0; i < 3000; i++) begin
        logic [15:0] a, d;
        if (run == 0) begin
          vs  = ~vs;
          run = int'($urandom_range(1, 6));
        end
        run--;
        case ($urandom_range(0, 3))
          0:       a = 16'($urandom);
          1:       a = 16'($urandom_range(5990, 6030));
          default: a = 16'(6000 + 4 * $urandom_range(0, 5));
        endcase
        d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 800));
        apply(1'($urandom_range(0, 1)), a, d, vs);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
